seq_alu: RTL and testbench

Multi-cycle, parametrised successor of the 3-bit calculator ALU: add, subtract, multiply and remainder on WIDTH-bit unsigned operands.
- Iterative shift-add multiply and restoring division replace the combinational multiplier/remainder units.
- Results are registered, with zero and divide-by-zero flags, behind a valid/ready handshake.
- Sits between the calculator's operand/keypad capture logic and the display driver.

---
 rtl/alu_pkg.sv | 11 +
 rtl/seq_alu_if.sv | 37 +++
 rtl/seq_divider.sv | 57 +++++
 rtl/seq_alu.sv | 166 ++++++++++++++++
 tb/tb_seq_alu.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential calculator ALU: opcodes and FSM states.
package alu_pkg;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_REM = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bus of seq_alu. Optional quotient output: ALU_QUOT_EN.
interface seq_alu_if #(parameter int WIDTH = 3);
   import alu_pkg::*;

   localparam int RES_W = 2*WIDTH;

   logic [1:0]       S;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             in_valid;
   logic             in_ready;
   logic [RES_W-1:0] answer;
   logic             DZ;
   logic             Z;
   logic             out_valid;
   logic             out_ready;
`ifdef ALU_QUOT_EN
   logic [WIDTH-1:0] quot;
`endif

   modport master (
      output S, A, B, in_valid, out_ready,
      input  in_ready, answer, DZ, Z, out_valid
`ifdef ALU_QUOT_EN
      , quot
`endif
   );

   modport slave (
      input  S, A, B, in_valid, out_ready,
      output in_ready, answer, DZ, Z, out_valid
`ifdef ALU_QUOT_EN
      , quot
`endif
   );

endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per enable pulse, MSB first.
// The *_nxt outputs show the register values after the current step so the
// caller can capture the final result on the same edge as the last step.
// Quotient output only exists with ALU_QUOT_EN.
module seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_nxt_o
`ifdef ALU_QUOT_EN
   ,
   output logic [WIDTH-1:0] quot_nxt_o
`endif
);

   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [WIDTH-1:0] rem_d, quo_d;
   logic [WIDTH:0]   part;
   logic             ge;

   // Shift the next dividend bit into the partial remainder and try a subtract.
   always_comb begin
      part  = {rem_q, quo_q[WIDTH-1]};
      ge    = (part >= {1'b0, dvs_q});
      rem_d = ge ? WIDTH'(part - {1'b0, dvs_q}) : part[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
   end

   // Work registers: quotient register starts holding the dividend.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
      end else if (en_i) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
      end
   end

   assign rem_nxt_o  = rem_d;
`ifdef ALU_QUOT_EN
   assign quot_nxt_o = quo_d;
`endif

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle calculator ALU: add/sub in one step, shift-add multiply and
// restoring remainder in WIDTH steps, result held behind valid/ready.
// Optional quotient output: ALU_QUOT_EN.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic     clk,
   input  logic     rst,
   seq_alu_if.slave bus
);

   localparam int RES_W = 2*WIDTH;
   localparam int CNT_W = $clog2(WIDTH+1);

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RES_W-1:0] mcand_q, mcand_d, acc_q, acc_d, ans_q, ans_d;
   logic [RES_W-1:0] acc_nx, res;
   logic [WIDTH-1:0] mplier_q, mplier_d, rem_nxt;
   logic             dz_q, dz_d, z_q, z_d;
   logic             div_load, div_en, last;
`ifdef ALU_QUOT_EN
   logic [WIDTH-1:0] quot_q, quot_d, quot_nxt;
`endif

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .rst        (rst),
      .load_i     (div_load),
      .en_i       (div_en),
      .dividend_i (bus.A),
      .divisor_i  (bus.B),
      .rem_nxt_o  (rem_nxt)
`ifdef ALU_QUOT_EN
      ,
      .quot_nxt_o (quot_nxt)
`endif
   );

   // Next-state, datapath step and result capture.
   // mcand_q/mplier_q double as the latched A/B for add and sub.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      ans_d    = ans_q;
      dz_d     = dz_q;
      z_d      = z_q;
      div_load = 1'b0;
      div_en   = 1'b0;
      last     = 1'b0;
      res      = '0;
      acc_nx   = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef ALU_QUOT_EN
      quot_d   = quot_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               op_d     = bus.S;
               cnt_d    = '0;
               mcand_d  = RES_W'(bus.A);
               mplier_d = bus.B;
               acc_d    = '0;
               div_load = 1'b1;
               if (bus.S == OP_REM && bus.B == '0) begin
                  state_d = DONE;
                  ans_d   = '0;
                  dz_d    = 1'b1;
                  z_d     = 1'b1;
`ifdef ALU_QUOT_EN
                  quot_d  = '1;
`endif
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + 1'b1;
            case (op_q)
               OP_ADD: begin
                  res  = mcand_q + RES_W'(mplier_q);
                  last = 1'b1;
               end
               OP_SUB: begin
                  res  = mcand_q - RES_W'(mplier_q);
                  last = 1'b1;
               end
               OP_MUL: begin
                  acc_d    = acc_nx;
                  mcand_d  = mcand_q << 1;
                  mplier_d = mplier_q >> 1;
                  res      = acc_nx;
                  last     = (cnt_q == CNT_W'(WIDTH-1));
               end
               default: begin
                  div_en = 1'b1;
                  res    = RES_W'(rem_nxt);
                  last   = (cnt_q == CNT_W'(WIDTH-1));
               end
            endcase
            if (last) begin
               state_d = DONE;
               ans_d   = res;
               z_d     = (res == '0);
               dz_d    = 1'b0;
`ifdef ALU_QUOT_EN
               quot_d  = (op_q == OP_REM) ? quot_nxt : '0;
`endif
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and work registers; reset overrides any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         ans_q    <= '0;
         dz_q     <= 1'b0;
         z_q      <= 1'b0;
`ifdef ALU_QUOT_EN
         quot_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         ans_q    <= ans_d;
         dz_q     <= dz_d;
         z_q      <= z_d;
`ifdef ALU_QUOT_EN
         quot_q   <= quot_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.answer    = ans_q;
   assign bus.DZ        = dz_q;
   assign bus.Z         = z_q;
`ifdef ALU_QUOT_EN
   assign bus.quot      = quot_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=3.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W = 3;

   typedef struct {
      logic [1:0] s;
      logic [2:0] a;
      logic [2:0] b;
      logic [5:0] ans;
      logic       dz;
      int         lat;
      logic [2:0] q;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [14];

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one request at a negedge, measure latency, check result, handshake.
   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      string tag;
      tag = $sformatf("v%0d", idx);
      bus.S = v.s; bus.A = v.a; bus.B = v.b; bus.in_valid = 1'b1;
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.A = ~v.a; bus.B = ~v.b; bus.S = ~v.s;   // late operand changes must not matter
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(v.lat));
      chk({tag, " answer"}, 32'(bus.answer), 32'(v.ans));
      chk({tag, " Z"}, 32'(bus.Z), 32'(v.ans == 6'd0));
      chk({tag, " DZ"}, 32'(bus.DZ), 32'(v.dz));
`ifdef ALU_QUOT_EN
      chk({tag, " quot"}, 32'(bus.quot), 32'(v.q));
`endif
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{OP_ADD, 3'd7, 3'd6, 6'd13, 1'b0, 2, 3'd0};
      vecs[1]  = '{OP_SUB, 3'd3, 3'd5, 6'b111110, 1'b0, 2, 3'd0};
      vecs[2]  = '{OP_SUB, 3'd4, 3'd4, 6'd0, 1'b0, 2, 3'd0};
      vecs[3]  = '{OP_MUL, 3'd7, 3'd7, 6'd49, 1'b0, 4, 3'd0};
      vecs[4]  = '{OP_MUL, 3'd0, 3'd5, 6'd0, 1'b0, 4, 3'd0};
      vecs[5]  = '{OP_REM, 3'd7, 3'd3, 6'd1, 1'b0, 4, 3'd2};
      vecs[6]  = '{OP_REM, 3'd5, 3'd0, 6'd0, 1'b1, 1, 3'd7};
      vecs[7]  = '{OP_ADD, 3'd0, 3'd0, 6'd0, 1'b0, 2, 3'd0};
      vecs[8]  = '{OP_ADD, 3'd7, 3'd7, 6'd14, 1'b0, 2, 3'd0};
      vecs[9]  = '{OP_SUB, 3'd0, 3'd7, 6'd57, 1'b0, 2, 3'd0};
      vecs[10] = '{OP_MUL, 3'd5, 3'd6, 6'd30, 1'b0, 4, 3'd0};
      vecs[11] = '{OP_REM, 3'd6, 3'd7, 6'd6, 1'b0, 4, 3'd0};
      vecs[12] = '{OP_REM, 3'd7, 3'd1, 6'd0, 1'b0, 4, 3'd7};
      vecs[13] = '{OP_MUL, 3'd3, 3'd2, 6'd6, 1'b0, 4, 3'd0};

      bus.S = OP_ADD; bus.A = '0; bus.B = '0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst answer", 32'(bus.answer), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst DZ", 32'(bus.DZ), 32'd0);
      chk("rst Z", 32'(bus.Z), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Reset in the middle of a multiply
      bus.S = OP_MUL; bus.A = 3'd7; bus.B = 3'd7; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst answer", 32'(bus.answer), 32'd0);
      chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst Z", 32'(bus.Z), 32'd0);
      chk("midrst DZ", 32'(bus.DZ), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst in_ready", 32'(bus.in_ready), 32'd1);
      repeat (4) @(negedge clk);
      chk("midrst no stale result", 32'(bus.out_valid), 32'd0);

      // Backpressure with in_valid held and operands changing
      bus.S = OP_ADD; bus.A = 3'd2; bus.B = 3'd3; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.S = OP_MUL;
      @(negedge clk);
      chk("bp out_valid", 32'(bus.out_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         bus.A = 3'(c + 3); bus.B = 3'(7 - c);
         chk($sformatf("bp answer c%0d", c), 32'(bus.answer), 32'd5);
         chk($sformatf("bp in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
         chk($sformatf("bp hold c%0d", c), 32'(bus.out_valid), 32'd1);
         @(negedge clk);
      end
      bus.S = OP_ADD; bus.A = 3'd1; bus.B = 3'd2;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("bp handshake drop", 32'(bus.out_valid), 32'd0);
      chk("bp in_ready after", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.A = 3'd7; bus.B = 3'd7;
      chk("bp second accepted", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk("bp second valid", 32'(bus.out_valid), 32'd1);
      chk("bp second answer", 32'(bus.answer), 32'd3);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
